// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and sequencer states shared by the ALU sequencer
package alu_pkg;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_E = 3;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_B, ST_WAIT_OP, ST_CALC, ST_SEND} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result and {E,V,C,Z} flags
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OPERADOR = 6
) (
  input  logic [NB_DATA-1:0]     i_a,
  input  logic [NB_DATA-1:0]     i_b,
  input  logic [NB_OPERADOR-1:0] i_op,
  output logic [NB_DATA-1:0]     o_res,
  output logic [3:0]             o_flags
);
  localparam int M = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] NB_W = NB_DATA'(NB_DATA);
  logic [NB_DATA:0] sum, dif;
  logic big;
  always_comb begin
    sum = {1'b0, i_a} + {1'b0, i_b};
    dif = {1'b0, i_a} - {1'b0, i_b};
    big = i_b >= NB_W;
    o_res = '0;
    o_flags = '0;
    case (i_op)
      NB_OPERADOR'(OP_ADD): begin
        o_res = sum[M:0];
        o_flags[FLAG_C] = sum[NB_DATA];
        o_flags[FLAG_V] = (i_a[M] == i_b[M]) && (sum[M] != i_a[M]);
      end
      NB_OPERADOR'(OP_SUB): begin
        o_res = dif[M:0];
        o_flags[FLAG_C] = dif[NB_DATA];
        o_flags[FLAG_V] = (i_a[M] != i_b[M]) && (dif[M] != i_a[M]);
      end
      NB_OPERADOR'(OP_AND): o_res = i_a & i_b;
      NB_OPERADOR'(OP_OR):  o_res = i_a | i_b;
      NB_OPERADOR'(OP_XOR): o_res = i_a ^ i_b;
      NB_OPERADOR'(OP_NOR): o_res = ~(i_a | i_b);
      NB_OPERADOR'(OP_SRA): o_res = big ? {NB_DATA{i_a[M]}} : $unsigned($signed(i_a) >>> i_b);
      NB_OPERADOR'(OP_SRL): o_res = big ? '0 : i_a >> i_b;
      NB_OPERADOR'(OP_SLL): o_res = big ? '0 : i_a << i_b;
      default:              o_flags[FLAG_E] = 1'b1;
    endcase
    o_flags[FLAG_Z] = o_res == '0;
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: collects A, B, opcode from a receiver, computes once, hands result to a transmitter
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OPERADOR = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [3:0]         o_flags,
  output logic               o_busy
);
  state_t state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d, alu_res;
  logic [NB_OPERADOR-1:0] op_q, op_d;
  logic [3:0] flags_q, flags_d, alu_flags;
  logic tx_start_q, tx_start_d;
  alu_core #(.NB_DATA(NB_DATA), .NB_OPERADOR(NB_OPERADOR)) u_core (
    .i_a(a_q), .i_b(b_q), .i_op(op_q), .o_res(alu_res), .o_flags(alu_flags)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    tx_data_d = tx_data_q;
    flags_d = flags_q;
    tx_start_d = 1'b0;
    case (state_q)
      ST_IDLE: if (i_rx_done) begin
        a_d = i_rx_data;
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: if (i_rx_done) begin
        b_d = i_rx_data;
        state_d = ST_WAIT_OP;
      end
      ST_WAIT_OP: if (i_rx_done) begin
        op_d = i_rx_data[NB_OPERADOR-1:0];
        state_d = ST_CALC;
      end
      ST_CALC: begin
        tx_data_d = alu_res;
        flags_d = alu_flags;
        tx_start_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: if (i_tx_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      tx_data_q <= '0;
      flags_q <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      tx_data_q <= tx_data_d;
      flags_q <= flags_d;
      tx_start_q <= tx_start_d;
    end
  end
  assign o_tx_data = tx_data_q;
  assign o_flags = flags_q;
  assign o_tx_start = tx_start_q;
  assign o_busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: random and directed stimulus against a transaction-level reference model
module tb_alu_seq_ctrl;
  logic clk = 0, rst_n = 0;
  logic [7:0] rx_data = 0;
  logic rx_done = 0, tx_done = 0;
  logic [7:0] tx_data;
  logic tx_start, busy;
  logic [3:0] flags;
  logic [15:0] rx16 = 0;
  logic rx_done16 = 0, tx_done16 = 0;
  logic [15:0] tx_data16;
  logic tx_start16, busy16;
  logic [3:0] flags16;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_seq_ctrl #(.NB_DATA(8), .NB_OPERADOR(6)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_flags(flags), .o_busy(busy)
  );
  alu_seq_ctrl #(.NB_DATA(16), .NB_OPERADOR(6)) d16 (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx16), .i_rx_done(rx_done16),
    .i_tx_done(tx_done16), .o_tx_data(tx_data16), .o_tx_start(tx_start16), .o_flags(flags16), .o_busy(busy16)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Reference ALU on plain integers; flags returned as {E,V,C,Z}
  function automatic void ref_alu(input int nb, input longint a, input longint b, input int op,
                                  output longint res, output logic [3:0] fl);
    longint m, half, sa, sb, s;
    m = (longint'(1) << nb) - 1;
    half = longint'(1) << (nb - 1);
    sa = a >= half ? a - (m + 1) : a;
    sb = b >= half ? b - (m + 1) : b;
    fl = 0;
    res = 0;
    case (op)
      6'b100000: begin
        s = a + b; res = s & m; fl[1] = s > m;
        s = sa + sb; fl[2] = s >= half || s < -half;
      end
      6'b100010: begin
        res = (a - b) & m; fl[1] = a < b;
        s = sa - sb; fl[2] = s >= half || s < -half;
      end
      6'b100100: res = a & b;
      6'b100101: res = a | b;
      6'b100110: res = a ^ b;
      6'b100111: res = ~(a | b) & m;
      6'b000011: res = (b >= nb ? (sa < 0 ? -1 : 0) : sa >>> b) & m;
      6'b000010: res = b >= nb ? 0 : a >> b;
      6'b000000: res = (a << b) & m;
      default:   fl[3] = 1;
    endcase
    fl[0] = res == 0;
  endfunction
  int ph = 0;
  longint w[3];
  longint r;
  logic [3:0] f;
  logic [7:0] e_data = 0;
  logic [3:0] e_fl = 0;
  logic e_start = 0;
  // ph counts words collected (0..2), 3 = computing, 4 = result offered
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; e_data = 0; e_fl = 0; e_start = 0;
    end else begin
      e_start = 0;
      if (ph < 3) begin
        if (rx_done) begin w[ph] = longint'(rx_data); ph++; end
      end else if (ph == 3) begin
        ref_alu(8, w[0], w[1], int'(w[2]) & 63, r, f);
        e_data = r[7:0]; e_fl = f; e_start = 1; ph = 4;
      end else if (tx_done) ph = 0;
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, ph != 0);
    chk("tx_start", tx_start, e_start);
    chk("tx_data", tx_data, e_data);
    chk("flags", flags, e_fl);
  end
  task automatic send_word(input logic [7:0] wd);
    @(posedge clk); #1;
    rx_data = wd; rx_done = 1;
    @(posedge clk); #1;
    rx_done = 0;
  endtask
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] xd, input logic [3:0] xf, input int hold);
    send_word(a); send_word(b); send_word(op);
    chk({nm, "_calc_nostart"}, tx_start, 0);
    @(posedge clk); #1;
    chk({nm, "_start"}, tx_start, 1);
    chk({nm, "_data"}, tx_data, xd);
    chk({nm, "_flags"}, flags, xf);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk({nm, "_hold_busy"}, busy, 1);
      chk({nm, "_hold_start"}, tx_start, 0);
      chk({nm, "_hold_data"}, tx_data, xd);
    end
    tx_done = 1;
    @(posedge clk); #1;
    tx_done = 0;
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_kept"}, tx_data, xd);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  logic [5:0] ops[9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                         6'b100111, 6'b000011, 6'b000010, 6'b000000};
  initial begin
    logic [7:0] a, b, op;
    int t;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy16", busy16, 0);
    #10 rst_n = 1;
    run_op("add_ovf", 8'h7F, 8'h01, 8'h20, 8'h80, 4'b0100, 0);
    run_op("sub_hold", 8'h05, 8'h07, 8'h22, 8'hFE, 4'b0010, 20);
    run_op("sra_big", 8'h90, 8'h09, 8'h03, 8'hFF, 4'b0000, 0);
    run_op("srl", 8'h90, 8'h02, 8'h02, 8'h24, 4'b0000, 0);
    run_op("sll", 8'h81, 8'h01, 8'h00, 8'h02, 4'b0000, 0);
    send_word(8'h12); send_word(8'h34); send_word(8'h3F);
    @(posedge clk); #1;
    chk("undef_data", tx_data, 8'h00);
    chk("undef_flags", flags, 4'b1001);
    rx_data = 8'hAA; rx_done = 1;
    @(posedge clk); #1;
    rx_done = 0;
    chk("undef_rx_ignored", busy, 1);
    rx_data = 8'hBB; rx_done = 1; tx_done = 1;
    @(posedge clk); #1;
    rx_done = 0; tx_done = 0;
    chk("undef_both_idle", busy, 0);
    run_op("after_send", 8'h11, 8'h22, 8'h20, 8'h33, 4'b0000, 0);
    send_word(8'h10); send_word(8'h20);
    #3 rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_data", tx_data, 0);
    chk("async_rst_flags", flags, 0);
    chk("async_rst_start", tx_start, 0);
    #12 rst_n = 1;
    run_op("post_rst", 8'h03, 8'h04, 8'h20, 8'h07, 4'b0000, 0);
    foreach (ops[i]) begin
      @(posedge clk); #1;
      rx16 = i == 0 ? 16'h7FFF : (i == 1 ? 16'h0001 : 16'h0020);
      rx_done16 = 1;
      @(posedge clk); #1;
      rx_done16 = 0;
      if (i == 2) break;
    end
    @(posedge clk); #1;
    chk("w16_start", tx_start16, 1);
    chk("w16_data", tx_data16, 16'h8000);
    chk("w16_flags", flags16, 4'b0100);
    tx_done16 = 1;
    @(posedge clk); #1;
    tx_done16 = 0;
    chk("w16_idle", busy16, 0);
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom);
      b = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 10)) : 8'($urandom);
      t = $urandom_range(0, 9);
      op = {2'($urandom), t < 9 ? ops[t] : 6'($urandom)};
      repeat ($urandom_range(0, 2)) begin
        tx_done = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        tx_done = 0;
      end
      send_word(a); send_word(b); send_word(op);
      if ($urandom_range(0, 3) == 0) begin
        rx_data = 8'($urandom); rx_done = 1;
        @(posedge clk); #1;
        rx_done = 0;
      end
      t = 0;
      while (tx_start !== 1'b1 && t < 8) begin
        @(posedge clk); #1;
        t++;
      end
      chk("rand_start_seen", tx_start, 1);
      repeat ($urandom_range(0, 3)) begin
        rx_data = 8'($urandom); rx_done = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        rx_done = 0;
      end
      rx_data = 8'($urandom); rx_done = 1'($urandom_range(0, 1)); tx_done = 1;
      @(posedge clk); #1;
      rx_done = 0; tx_done = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
